axi_stream_tx_prot_corrector: RTL and testbench

- Tx-path stage sitting directly downstream of the AXI-Stream decoupler, between the decoupled region's egress stream and the shared network fabric.
- Registers every beat so downstream timing and signal stability never depend on the region.
- Splits packets that exceed a maximum length by forcing tlast, and reports the forced-tlast handshake combinationally back to the decoupler via axis_tx_tlast_forced.
- Flags protocol violations in a sticky status vector.

---
 rtl/axi_stream_tx_prot_corrector.sv | 110 +++++++++++
 tb/tb_axi_stream_tx_prot_corrector.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/axi_stream_tx_prot_corrector.sv
// axi_stream_tx_prot_corrector: registered tx slice that splits over-long packets and flags sticky protocol errors
module axi_stream_tx_prot_corrector #(
    parameter int AXIS_BUS_WIDTH   = 64,
    parameter int AXIS_ID_WIDTH    = 4,
    parameter int AXIS_DEST_WIDTH  = 4,
    parameter int MAX_PACKET_BEATS = 256,
    localparam int IW = AXIS_ID_WIDTH > 0 ? AXIS_ID_WIDTH : 1,
    localparam int DW = AXIS_DEST_WIDTH > 0 ? AXIS_DEST_WIDTH : 1,
    localparam int KW = AXIS_BUS_WIDTH / 8,
    localparam int CW = $clog2(MAX_PACKET_BEATS + 1)
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [AXIS_BUS_WIDTH-1:0] axis_in_tdata,
    input  logic [IW-1:0]             axis_in_tid,
    input  logic [DW-1:0]             axis_in_tdest,
    input  logic [KW-1:0]             axis_in_tkeep,
    input  logic                      axis_in_tlast,
    input  logic                      axis_in_tvalid,
    output logic                      axis_in_tready,
    output logic [AXIS_BUS_WIDTH-1:0] axis_out_tdata,
    output logic [IW-1:0]             axis_out_tid,
    output logic [DW-1:0]             axis_out_tdest,
    output logic [KW-1:0]             axis_out_tkeep,
    output logic                      axis_out_tlast,
    output logic                      axis_out_tvalid,
    input  logic                      axis_out_tready,
    output logic                      axis_tx_tlast_forced,
    input  logic                      err_clear,
    output logic [3:0]                err_status
);
    logic [AXIS_BUS_WIDTH-1:0] data_q, data_d, s_data_q;
    logic [IW-1:0]             id_q, id_d, s_id_q;
    logic [DW-1:0]             dest_q, dest_d, s_dest_q;
    logic [KW-1:0]             keep_q, keep_d, s_keep_q;
    logic                      last_q, last_d, s_last_q;
    logic                      valid_q, valid_d, stalled_q, stalled_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [3:0]                err_q, err_d;
    logic                      accept, force_last, eff_last, diff;

    assign axis_in_tready       = aresetn && (!valid_q || axis_out_tready);
    assign accept               = axis_in_tvalid && axis_in_tready;
    assign force_last           = (cnt_q == CW'(MAX_PACKET_BEATS - 1)) && !axis_in_tlast;
    assign eff_last             = axis_in_tlast || force_last;
    assign axis_tx_tlast_forced = accept && force_last;
    assign axis_out_tdata       = data_q;
    assign axis_out_tid         = id_q;
    assign axis_out_tdest       = dest_q;
    assign axis_out_tkeep       = keep_q;
    assign axis_out_tlast       = last_q;
    assign axis_out_tvalid      = valid_q;
    assign err_status           = err_q;

    // Zero-width id/dest ports are placeholders and must not raise DATA_CHANGE
    assign diff = axis_in_tdata != s_data_q || axis_in_tkeep != s_keep_q || axis_in_tlast != s_last_q
               || (AXIS_ID_WIDTH > 0 && axis_in_tid != s_id_q)
               || (AXIS_DEST_WIDTH > 0 && axis_in_tdest != s_dest_q);

    always_comb begin
        valid_d   = accept || (valid_q && !axis_out_tready);
        data_d    = accept ? axis_in_tdata : data_q;
        id_d      = accept ? axis_in_tid : id_q;
        dest_d    = accept ? axis_in_tdest : dest_q;
        keep_d    = accept ? axis_in_tkeep : keep_q;
        last_d    = accept ? eff_last : last_q;
        cnt_d     = !accept ? cnt_q : eff_last ? '0 : cnt_q + CW'(1);
        stalled_d = axis_in_tvalid && !axis_in_tready;
        err_d     = (err_clear ? 4'b0 : err_q) | {
            accept && axis_in_tkeep == '0,
            accept && !eff_last && axis_in_tkeep != '1,
            stalled_q && axis_in_tvalid && diff,
            stalled_q && !axis_in_tvalid
        };
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            id_q      <= '0;
            dest_q    <= '0;
            keep_q    <= '0;
            last_q    <= 1'b0;
            cnt_q     <= '0;
            err_q     <= '0;
            stalled_q <= 1'b0;
            s_data_q  <= '0;
            s_id_q    <= '0;
            s_dest_q  <= '0;
            s_keep_q  <= '0;
            s_last_q  <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            id_q      <= id_d;
            dest_q    <= dest_d;
            keep_q    <= keep_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            stalled_q <= stalled_d;
            s_data_q  <= axis_in_tdata;
            s_id_q    <= axis_in_tid;
            s_dest_q  <= axis_in_tdest;
            s_keep_q  <= axis_in_tkeep;
            s_last_q  <= axis_in_tlast;
        end
    end
endmodule

// File: tb/tb_axi_stream_tx_prot_corrector.sv
// tb_axi_stream_tx_prot_corrector: directed table and sequence checks with MAX_PACKET_BEATS=4
module tb_axi_stream_tx_prot_corrector;
    logic        aclk = 1'b0, aresetn = 1'b0;
    logic [63:0] in_data = '0, out_data;
    logic [3:0]  in_id = 4'h5, in_dest = 4'hA, out_id, out_dest;
    logic [7:0]  in_keep = '0, out_keep;
    logic        in_last = 1'b0, in_valid = 1'b0, in_ready;
    logic        out_last, out_valid, out_ready = 1'b0, forced, err_clear = 1'b0;
    logic [3:0]  err;
    int          checks = 0, errors = 0;

    typedef struct {
        logic        v, l;
        logic [7:0]  k;
        logic [63:0] d;
        logic        r;
        logic        ir, f, ov, ol;
        logic [63:0] od;
        logic [3:0]  e;
    } vec_t;
    vec_t vecs[15];

    axi_stream_tx_prot_corrector #(.AXIS_BUS_WIDTH(64), .AXIS_ID_WIDTH(4), .AXIS_DEST_WIDTH(4),
        .MAX_PACKET_BEATS(4)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .axis_in_tdata(in_data), .axis_in_tid(in_id), .axis_in_tdest(in_dest), .axis_in_tkeep(in_keep),
        .axis_in_tlast(in_last), .axis_in_tvalid(in_valid), .axis_in_tready(in_ready),
        .axis_out_tdata(out_data), .axis_out_tid(out_id), .axis_out_tdest(out_dest), .axis_out_tkeep(out_keep),
        .axis_out_tlast(out_last), .axis_out_tvalid(out_valid), .axis_out_tready(out_ready),
        .axis_tx_tlast_forced(forced), .err_clear(err_clear), .err_status(err)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic l, input logic [7:0] k, input logic [63:0] d,
                        input logic r, input logic c);
        @(negedge aclk);
        in_valid = v; in_last = l; in_keep = k; in_data = d; out_ready = r; err_clear = c;
        #1;
    endtask

    initial begin
        //           v  l  keep   data   r  ir f  ov ol out    err
        vecs[0]  = '{1, 0, 8'hFF, 64'h1,  1, 1, 0, 0, 0, 64'h0,  4'h0};
        vecs[1]  = '{1, 0, 8'hFF, 64'h2,  1, 1, 0, 1, 0, 64'h1,  4'h0};
        vecs[2]  = '{1, 1, 8'hFF, 64'h3,  1, 1, 0, 1, 0, 64'h2,  4'h0};
        vecs[3]  = '{1, 0, 8'hFF, 64'h10, 1, 1, 0, 1, 1, 64'h3,  4'h0};
        vecs[4]  = '{1, 0, 8'hFF, 64'h11, 1, 1, 0, 1, 0, 64'h10, 4'h0};
        vecs[5]  = '{1, 0, 8'hFF, 64'h12, 1, 1, 0, 1, 0, 64'h11, 4'h0};
        vecs[6]  = '{1, 0, 8'hFF, 64'h13, 1, 1, 1, 1, 0, 64'h12, 4'h0};
        vecs[7]  = '{1, 0, 8'hFF, 64'h14, 1, 1, 0, 1, 1, 64'h13, 4'h0};
        vecs[8]  = '{1, 0, 8'hFF, 64'h15, 1, 1, 0, 1, 0, 64'h14, 4'h0};
        vecs[9]  = '{1, 0, 8'hFF, 64'h16, 1, 1, 0, 1, 0, 64'h15, 4'h0};
        vecs[10] = '{1, 0, 8'hFF, 64'h17, 1, 1, 1, 1, 0, 64'h16, 4'h0};
        vecs[11] = '{1, 0, 8'hFF, 64'h18, 1, 1, 0, 1, 1, 64'h17, 4'h0};
        vecs[12] = '{1, 1, 8'hFF, 64'h19, 1, 1, 0, 1, 0, 64'h18, 4'h0};
        vecs[13] = '{0, 0, 8'hFF, 64'h0,  1, 1, 0, 1, 1, 64'h19, 4'h0};
        vecs[14] = '{0, 0, 8'hFF, 64'h0,  1, 1, 0, 0, 1, 64'h19, 4'h0};

        #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset in_ready", in_ready, 0);
        chk("reset forced", forced, 0);
        chk("reset err", err, 0);
        chk("reset out_data", out_data, 0);
        @(negedge aclk); aresetn = 1'b1;

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].v, vecs[i].l, vecs[i].k, vecs[i].d, vecs[i].r, 0);
            chk($sformatf("v%0d in_ready", i), in_ready, vecs[i].ir);
            chk($sformatf("v%0d forced", i), forced, vecs[i].f);
            chk($sformatf("v%0d out_valid", i), out_valid, vecs[i].ov);
            chk($sformatf("v%0d out_last", i), out_last, vecs[i].ol);
            chk($sformatf("v%0d out_data", i), out_data, vecs[i].od);
            chk($sformatf("v%0d err", i), err, vecs[i].e);
        end
        chk("out tid", out_id, 4'h5);
        chk("out tdest", out_dest, 4'hA);

        // output stalled for five cycles with a compliant upstream
        step(1, 0, 8'hFF, 64'hA0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 8'hFF, 64'hA1, 0, 0);
            chk($sformatf("stall%0d in_ready", i), in_ready, 0);
            chk($sformatf("stall%0d out_data", i), out_data, 64'hA0);
            chk($sformatf("stall%0d out_valid", i), out_valid, 1);
        end
        step(1, 0, 8'hFF, 64'hA1, 1, 0);
        chk("unstall in_ready", in_ready, 1);
        step(1, 1, 8'hFF, 64'hA2, 1, 0);
        chk("stall next data", out_data, 64'hA1);
        step(0, 0, 8'hFF, 64'h0, 1, 0);
        chk("stall last data", out_data, 64'hA2);
        chk("stall last tlast", out_last, 1);
        chk("stall err", err, 0);

        // VALID_DROP then DATA_CHANGE, then clear
        step(1, 0, 8'hFF, 64'hB0, 1, 0);
        step(1, 0, 8'hFF, 64'hB1, 0, 0);
        step(0, 0, 8'hFF, 64'h0, 0, 0);
        step(0, 0, 8'hFF, 64'h0, 1, 0);
        chk("valid drop err", err, 4'h1);
        step(1, 0, 8'hFF, 64'hB1, 1, 0);
        step(1, 0, 8'hFF, 64'hB2, 0, 0);
        step(1, 0, 8'hFF, 64'hB3, 0, 0);
        step(1, 1, 8'hFF, 64'hB3, 1, 0);
        chk("data change err", err, 4'h3);
        step(0, 0, 8'hFF, 64'h0, 1, 1);
        chk("err before clear", err, 4'h3);
        step(0, 0, 8'hFF, 64'h0, 1, 0);
        chk("err cleared", err, 4'h0);

        // sparse keep mid-packet, then empty keep on tlast
        step(1, 0, 8'h0F, 64'hC0, 1, 0);
        step(1, 1, 8'h00, 64'hC1, 1, 0);
        chk("keep sparse err", err, 4'h4);
        chk("out tkeep", out_keep, 8'h0F);
        step(0, 0, 8'hFF, 64'h0, 1, 0);
        chk("keep empty err", err, 4'hC);
        step(0, 0, 8'hFF, 64'h0, 1, 1);
        step(0, 0, 8'hFF, 64'h0, 1, 0);
        chk("keep err cleared", err, 4'h0);

        // asynchronous reset mid-packet with a held beat
        step(1, 0, 8'hFF, 64'hD0, 0, 0);
        step(1, 0, 8'hFF, 64'hD1, 0, 0);
        chk("pre-reset out_valid", out_valid, 1);
        chk("pre-reset in_ready", in_ready, 0);
        #1 aresetn = 1'b0;
        #1;
        chk("async out_valid", out_valid, 0);
        chk("async in_ready", in_ready, 0);
        chk("async out_data", out_data, 0);
        step(0, 0, 8'hFF, 64'h0, 1, 0);
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1, i == 3, 8'hFF, 64'hE0 + 64'(i), 1, 0);
            chk($sformatf("post-reset forced%0d", i), forced, 0);
            if (i > 0) chk($sformatf("post-reset last%0d", i), out_last, 0);
        end
        step(0, 0, 8'hFF, 64'h0, 1, 0);
        chk("post-reset final data", out_data, 64'hE3);
        chk("post-reset final last", out_last, 1);
        chk("post-reset err", err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
